// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit for a captured data word; even or odd selected by par_typ.
// Latency: combinational, zero cycles.
// Backpressure: none, pure function of its inputs.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  output logic             par_bit
);

  // Even parity is the plain XOR reduction; odd parity is its complement.
  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// Serial UART transmitter: start, 8 data bits LSB first, optional parity, stop.
// Latency: start bit on the line from the edge that captures Data_Valid; 10/11 cycle frame.
// Backpressure: busy high during a frame; Data_Valid outside IDLE is dropped, not queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  state_t                  state;
  state_t                  next_state;
  logic [IDX_W-1:0]        idx;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    par_en_reg;
  logic                    par_typ_reg;
  logic                    par_bit;

  uart_parity_calc #(
    .WIDTH (DATA_WIDTH)
  ) u_parity (
    .data    (data_reg),
    .par_typ (par_typ_reg),
    .par_bit (par_bit)
  );

  // State register; reset aborts any frame at once.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Capture the request only while idle so in-flight frames are immune to
  // input changes; the index runs only in DATA and sits at zero elsewhere.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= PAR_EVEN;
      idx         <= '0;
    end else begin
      if (state == IDLE && Data_Valid) begin
        data_reg    <= P_DATA;
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
      end
      if (state == DATA) begin
        idx <= idx + 1'b1;
      end else begin
        idx <= '0;
      end
    end
  end

  // Next state and output mux, decoded from registered state/data/index only.
  always_comb begin
    next_state = state;
    TX_OUT     = STOP_BIT;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (Data_Valid) begin
          next_state = START;
        end
      end
      START: begin
        TX_OUT     = START_BIT;
        next_state = DATA;
      end
      DATA: begin
        TX_OUT = data_reg[idx];
        if (idx == LAST_IDX) begin
          next_state = par_en_reg ? PARITY : STOP;
        end
      end
      PARITY: begin
        TX_OUT     = par_bit;
        next_state = STOP;
      end
      STOP: begin
        next_state = IDLE;
      end
      default: begin
        busy       = 1'b0;
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level queue model plus literal sequences.
// Latency: checks start bit on the cycle after the capture edge.
// Backpressure: exercises dropped requests mid-frame and at the stop-to-idle edge.
module tb_uart_tx;

  logic       CLK_TB;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       busy;

  int checks_total;
  int checks_passed;

  // Model: remaining line bits of the frame in flight, front = current bit.
  logic model_q[$];

  uart_tx #(
    .DATA_WIDTH (8)
  ) dut (
    .CLK        (CLK_TB),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .busy       (busy)
  );

  initial CLK_TB = 1'b0;
  always #5 CLK_TB = ~CLK_TB;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks_total++;
    if (act === exp) begin
      checks_passed++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame builder: whole frame computed from the line rules when a request lands.
  always @(posedge CLK_TB or posedge RST) begin
    if (RST) begin
      model_q.delete();
    end else if (model_q.size() != 0) begin
      void'(model_q.pop_front());
    end else if (Data_Valid) begin
      int ones;
      ones = $countones(P_DATA);
      model_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) model_q.push_back(P_DATA[i]);
      if (PAR_EN) model_q.push_back(PAR_TYP ? ((ones % 2) == 0) : ((ones % 2) == 1));
      model_q.push_back(1'b1);
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge CLK_TB) begin
    logic exp_tx;
    logic exp_busy;
    exp_tx   = (model_q.size() != 0) ? model_q[0] : 1'b1;
    exp_busy = (model_q.size() != 0);
    chk("model_tx", {15'd0, TX_OUT}, {15'd0, exp_tx});
    chk("model_busy", {15'd0, busy}, {15'd0, exp_busy});
  end

  // Issue one request, then record 12 line samples (frame plus following idle).
  // inject_at >= 0 pulses a competing request after that sample.
  task automatic run_frame(input string nm, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic [11:0] exp_seq,
                           input int exp_busy, input int inject_at);
    logic [11:0] seq;
    int          bcnt;
    seq  = '0;
    bcnt = 0;
    @(posedge CLK_TB); #1;
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(posedge CLK_TB); #1;
    Data_Valid = 1'b0;
    P_DATA     = ~d;
    PAR_EN     = ~pen;
    PAR_TYP    = ~ptyp;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK_TB);
      seq  = {seq[10:0], TX_OUT};
      bcnt = bcnt + int'(busy);
      if (i == inject_at) begin
        Data_Valid = 1'b1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b1;
      end
      if (i == inject_at + 1) begin
        Data_Valid = 1'b0;
      end
    end
    chk({nm, "_seq"}, {4'd0, seq}, {4'd0, exp_seq});
    chk({nm, "_busy_cycles"}, 16'(bcnt), 16'(exp_busy));
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    RST        = 1'b1;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;

    // Reset held for 4 cycles, with a request present that must not start a frame.
    repeat (2) @(negedge CLK_TB);
    Data_Valid = 1'b1;
    repeat (2) @(negedge CLK_TB);
    chk("reset_tx", {15'd0, TX_OUT}, 16'd1);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    Data_Valid = 1'b0;
    RST        = 1'b0;
    repeat (2) @(negedge CLK_TB);
    chk("post_reset_tx", {15'd0, TX_OUT}, 16'd1);
    chk("post_reset_busy", {15'd0, busy}, 16'd0);

    // 0xA5, no parity: 0,1,0,1,0,0,1,0,1,1 then idle.
    run_frame("no_par_a5", 8'hA5, 1'b0, 1'b0, 12'b0101001011_11, 10, -1);
    // 0x5A, even parity: 0,0,1,0,1,1,0,1,0, parity 0, stop, idle.
    run_frame("even_5a", 8'h5A, 1'b1, 1'b0, 12'b001011010_0_1_1, 11, -1);
    // 0x3C, odd parity: 0,0,0,1,1,1,1,0,0, parity 1, stop, idle.
    run_frame("odd_3c", 8'h3C, 1'b1, 1'b1, 12'b000111100_1_1_1, 11, -1);
    // Same frame with a 0xFF request mid-frame: dropped, frame unchanged.
    run_frame("ignored_mid", 8'h3C, 1'b1, 1'b1, 12'b000111100_1_1_1, 11, 4);
    repeat (4) @(negedge CLK_TB);
    chk("no_second_frame_busy", {15'd0, busy}, 16'd0);
    chk("no_second_frame_tx", {15'd0, TX_OUT}, 16'd1);
    // Request on the stop-to-idle edge is also dropped.
    run_frame("ignored_stop", 8'h5A, 1'b1, 1'b0, 12'b001011010_0_1_1, 11, 10);
    repeat (4) @(negedge CLK_TB);
    chk("stop_edge_busy", {15'd0, busy}, 16'd0);

    // Reset at data bit 3 of 0xA5 (bit 3 is 0, so the line visibly returns high).
    @(posedge CLK_TB); #1;
    P_DATA     = 8'hA5;
    PAR_EN     = 1'b0;
    Data_Valid = 1'b1;
    @(posedge CLK_TB); #1;
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK_TB);
    chk("pre_abort_tx", {15'd0, TX_OUT}, 16'd0);
    chk("pre_abort_busy", {15'd0, busy}, 16'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("abort_tx", {15'd0, TX_OUT}, 16'd1);
    chk("abort_busy", {15'd0, busy}, 16'd0);
    repeat (2) @(negedge CLK_TB);
    RST = 1'b0;
    run_frame("after_abort", 8'hA5, 1'b0, 1'b0, 12'b0101001011_11, 10, -1);

    repeat (3) @(negedge CLK_TB);
    #1;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
